// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: assembles a word-streamed slice bitstream into a
// shadow image and commits it to the slice with a one-cycle cen pulse.
module slicel_cfg_loader #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 32,
  localparam int SXX_CFG_SIZE = 2*2**S_XX_BASE + 1,
  localparam int MUX_LVLS     = $clog2(NUM_LUTS),
  localparam int LUT_BITS     = SXX_CFG_SIZE*NUM_LUTS,
  localparam int CFG_BITS     = LUT_BITS + MUX_LVLS + 1,
  localparam int NUM_WORDS    = (CFG_BITS + WORD_W - 1) / WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cfg_valid,
  input  logic [WORD_W-1:0]   cfg_data,
  output logic                cfg_ready,
  output logic [LUT_BITS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0] inter_lut_mux_config,
  output logic                config_use_cc,
  output logic                cen,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(NUM_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] img_q, img_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      img_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  // Abort wins over a word on the same cycle; the last word's
  // overhang beyond CFG_BITS simply has no image bit to land in.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          wcnt_d  = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cfg_valid) begin
          for (int b = 0; b < CFG_BITS; b++) begin
            if (b / WORD_W == int'(wcnt_q)) begin
              img_d[b] = cfg_data[b % WORD_W];
            end
          end
          if (wcnt_q == LAST) begin
            state_d = COMMIT;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    cen       = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD: begin
        cfg_ready = ~abort;
        busy      = 1'b1;
      end
      COMMIT: begin
        cen  = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign done                 = done_q;
  assign luts_config_in       = img_q[LUT_BITS-1:0];
  assign inter_lut_mux_config = img_q[LUT_BITS +: MUX_LVLS];
  assign config_use_cc        = img_q[CFG_BITS-1];

endmodule
